// File: rtl/seg7_time_display.sv
// seg7_time_display: multiplexes BCD HH:MM (time or alarm) onto a 4-digit common-anode 7-segment display.
// Latency: an/seg/dp are registered and lag digit_sel by one cycle; digits are snapshotted once per scan frame.
// Backpressure: none; free-running scan driven by clk_100MHz, inputs sampled whenever the frame reloads.
//
// Ports:
//   clk_100MHz, reset (async, active-high)
//   tick_1Hz                 1 Hz square wave (same domain): DP seconds blink / alarm-mode display blink
//   set_alarm                1 = show alarm digits, 0 = show time digits
//   min_1s..hr_10s           BCD time digits
//   alarm_min_1s..alarm_hr_10s BCD alarm digits
//   seg[6:0]                 cathodes, active-low, seg[0]=a .. seg[6]=g
//   dp                       decimal point, active-low
//   an[3:0]                  anodes, active-low, an[0] = rightmost digit
// Optional macro SEG7_LEADING_ZERO_BLANK_EN: blanks digit 3 when the snapped hour-tens digit is 0.

module seg7_time_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       tick_1Hz,
  input  logic       set_alarm,
  input  logic [3:0] min_1s,
  input  logic [3:0] min_10s,
  input  logic [3:0] hr_1s,
  input  logic [3:0] hr_10s,
  input  logic [3:0] alarm_min_1s,
  input  logic [3:0] alarm_min_10s,
  input  logic [3:0] alarm_hr_1s,
  input  logic [3:0] alarm_hr_10s,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  typedef enum logic {BLINK_OFF = 1'b0, BLINK_ON = 1'b1} blink_t;

  logic [CNT_W-1:0] refresh_ctr_q, refresh_ctr_d;
  logic [1:0]       digit_sel_q, digit_sel_d;
  logic             snap_valid_q, snap_valid_d;
  logic             snap_mode_q, snap_mode_d;
  logic [3:0]       snap_m1_q, snap_m1_d;
  logic [3:0]       snap_m10_q, snap_m10_d;
  logic [3:0]       snap_h1_q, snap_h1_d;
  logic [3:0]       snap_h10_q, snap_h10_d;
  blink_t           blink_phase_q, blink_phase_d;
  // previous-cycle copies of tick_1Hz / set_alarm for edge detection
  logic             tick_dly_q, tick_dly_d;
  logic             set_dly_q, set_dly_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic             wrap;
  logic             snap_load;
  logic [3:0]       cur_digit;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111; // non-BCD shows a dash
    endcase
    return s;
  endfunction

  always_comb begin
    refresh_ctr_d = refresh_ctr_q;
    digit_sel_d   = digit_sel_q;
    snap_valid_d  = snap_valid_q;
    snap_mode_d   = snap_mode_q;
    snap_m1_d     = snap_m1_q;
    snap_m10_d    = snap_m10_q;
    snap_h1_d     = snap_h1_q;
    snap_h10_d    = snap_h10_q;
    blink_phase_d = blink_phase_q;
    tick_dly_d    = tick_1Hz;
    set_dly_d     = set_alarm;
    an_d          = 4'b1111;
    seg_d         = 7'b1111111;
    dp_d          = 1'b1;
    cur_digit     = 4'd0;

    // refresh counter / digit scan
    wrap = (refresh_ctr_q == CNT_W'(REFRESH_DIV - 1));
    if (wrap) begin
      refresh_ctr_d = '0;
      digit_sel_d   = digit_sel_q + 2'd1;
    end else begin
      refresh_ctr_d = refresh_ctr_q + CNT_W'(1);
    end

    // Reload on the last cycle of slot 3 so the new frame starts with fresh,
    // consistent digits; also load immediately after reset.
    snap_load = (wrap && (digit_sel_q == 2'd3)) || !snap_valid_q;
    if (snap_load) begin
      snap_valid_d = 1'b1;
      snap_mode_d  = set_alarm;
      if (set_alarm) begin
        snap_m1_d  = alarm_min_1s;
        snap_m10_d = alarm_min_10s;
        snap_h1_d  = alarm_hr_1s;
        snap_h10_d = alarm_hr_10s;
      end else begin
        snap_m1_d  = min_1s;
        snap_m10_d = min_10s;
        snap_h1_d  = hr_1s;
        snap_h10_d = hr_10s;
      end
    end

    // Entering alarm-set mode always starts in the visible phase, even if a
    // tick edge lands in the same cycle.
    if (set_alarm && !set_dly_q) begin
      blink_phase_d = BLINK_ON;
    end else if (tick_1Hz && !tick_dly_q) begin
      blink_phase_d = (blink_phase_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
    end

    // output stage
    case (digit_sel_q)
      2'd0:    cur_digit = snap_m1_q;
      2'd1:    cur_digit = snap_m10_q;
      2'd2:    cur_digit = snap_h1_q;
      default: cur_digit = snap_h10_q;
    endcase
    seg_d = seg_decode(cur_digit);

    if (snap_valid_q && !(snap_mode_q && (blink_phase_q == BLINK_OFF))) begin
      an_d = ~(4'b0001 << digit_sel_q);
    end
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if ((digit_sel_q == 2'd3) && (snap_h10_q == 4'd0)) begin
      an_d = 4'b1111;
    end
`endif

    // DP under hour-ones digit acts as the seconds colon in time mode
    dp_d = !((digit_sel_q == 2'd2) && !snap_mode_q && tick_1Hz);
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      refresh_ctr_q <= '0;
      digit_sel_q   <= 2'd0;
      snap_valid_q  <= 1'b0;
      snap_mode_q   <= 1'b0;
      snap_m1_q     <= 4'd0;
      snap_m10_q    <= 4'd0;
      snap_h1_q     <= 4'd0;
      snap_h10_q    <= 4'd0;
      blink_phase_q <= BLINK_ON;
      tick_dly_q    <= 1'b0;
      set_dly_q     <= 1'b0;
      an_q          <= 4'b1111;
      seg_q         <= 7'b1111111;
      dp_q          <= 1'b1;
    end else begin
      refresh_ctr_q <= refresh_ctr_d;
      digit_sel_q   <= digit_sel_d;
      snap_valid_q  <= snap_valid_d;
      snap_mode_q   <= snap_mode_d;
      snap_m1_q     <= snap_m1_d;
      snap_m10_q    <= snap_m10_d;
      snap_h1_q     <= snap_h1_d;
      snap_h10_q    <= snap_h10_d;
      blink_phase_q <= blink_phase_d;
      tick_dly_q    <= tick_dly_d;
      set_dly_q     <= set_dly_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
